// File: rtl/magic_glove_pkg.sv
// magic_glove_pkg: shared class/frame types and sequencer states for the gesture-to-text path
// Exports the class index width, the blank separator, frame and FSM state types.
package magic_glove_pkg;
  localparam int CW = 5;
  localparam int NUM_CLASSES = 27;
  localparam logic [CW-1:0] BLANK_CLASS = 5'd26;
  typedef logic [CW-1:0] class_t;
  typedef class_t tops_t [3];
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_COMMIT} state_t;
endpackage

// File: rtl/letter_fifo.sv
// letter_fifo: synchronous FIFO holding recognised letter class indices
// Ports: clk, rst (sync active-high), push/pop/flush controls, din write data,
// head = oldest entry, full/empty status flags.
module letter_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic do_push;
  assign empty = wr_q == rd_q;
  // Same slot, opposite wrap bit: the writer has lapped the reader.
  assign full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign head = mem_q[rd_q[AW-1:0]];
  assign do_push = push & ~full & ~flush;
  always_comb begin
    wr_d = flush ? '0 : wr_q + (AW+1)'(do_push);
    rd_d = flush ? '0 : rd_q + (AW+1)'(pop & ~empty);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/dedup_sequencer.sv
// dedup_sequencer: sequences one Dedup compare per classifier frame and queues new letters
// Ports: i_clk, i_rst_n (sync, active-high); frame in i_valid/i_tops/o_ready, i_clear;
// Dedup side o_dd_next/o_dd_tops/o_dd_prev_tops and i_dd_finished/i_dd_next;
// letter out o_letter/o_letter_valid/i_letter_ready; o_timeout; saturating counters.
module dedup_sequencer
  import magic_glove_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [4:0]       i_tops [3],
  output logic             o_ready,
  input  logic             i_clear,
  output logic             o_dd_next,
  output logic [4:0]       o_dd_tops [3],
  output logic [4:0]       o_dd_prev_tops [3],
  input  logic             i_dd_finished,
  input  logic             i_dd_next,
  output logic [4:0]       o_letter,
  output logic             o_letter_valid,
  input  logic             i_letter_ready,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_accept_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  tops_t cur_q, cur_d, prev_q, prev_d;
  logic prev_valid_q, prev_valid_d, dd_next_q, dd_next_d, timeout_q, timeout_d;
  logic clr_pend_q, clr_pend_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [CNT_W-1:0] acc_q, acc_d, drop_q, drop_d;
  logic accept, push, flush, full, empty;
  assign o_ready = (state_q == S_IDLE) & ~full & ~i_clear;
  assign accept = i_valid & o_ready;
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    prev_d = prev_q;
    prev_valid_d = prev_valid_q;
    wdog_d = wdog_q;
    dd_next_d = 1'b0;
    timeout_d = 1'b0;
    acc_d = acc_q;
    drop_d = drop_q;
    clr_pend_d = clr_pend_q;
    push = 1'b0;
    flush = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_clear) begin
          flush = 1'b1;
          prev_valid_d = 1'b0;
        end else if (accept) begin
          cur_d = i_tops;
          if (i_tops[0] == BLANK_CLASS) prev_valid_d = 1'b0;
          else if (!prev_valid_q) state_d = S_COMMIT;
          else begin
            state_d = S_START;
            dd_next_d = 1'b1;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
        wdog_d = '0;
      end
      S_WAIT: begin
        if (i_dd_finished) begin
          if (i_dd_next) state_d = S_COMMIT;
          else begin
            state_d = S_IDLE;
            prev_d = cur_q;
            drop_d = (&drop_q) ? drop_q : drop_q + 1'b1;
          end
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          prev_d = cur_q;
          timeout_d = 1'b1;
          drop_d = (&drop_q) ? drop_q : drop_q + 1'b1;
        end else wdog_d = wdog_q + 1'b1;
      end
      S_COMMIT: begin
        push = 1'b1;
        prev_d = cur_q;
        prev_valid_d = 1'b1;
        acc_d = (&acc_q) ? acc_q : acc_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A clear seen while busy is held and applied on the edge back into idle,
    // where the flush also discards the in-flight frame's push.
    if (state_q != S_IDLE) begin
      clr_pend_d = clr_pend_q | i_clear;
      if (state_d == S_IDLE && clr_pend_d) begin
        flush = 1'b1;
        prev_valid_d = 1'b0;
        clr_pend_d = 1'b0;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state_q <= S_IDLE;
      cur_q <= '{default: '0};
      prev_q <= '{default: '0};
      prev_valid_q <= 1'b0;
      wdog_q <= '0;
      dd_next_q <= 1'b0;
      timeout_q <= 1'b0;
      acc_q <= '0;
      drop_q <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      prev_q <= prev_d;
      prev_valid_q <= prev_valid_d;
      wdog_q <= wdog_d;
      dd_next_q <= dd_next_d;
      timeout_q <= timeout_d;
      acc_q <= acc_d;
      drop_q <= drop_d;
      clr_pend_q <= clr_pend_d;
    end
  end
  letter_fifo #(.DEPTH(FIFO_DEPTH), .W(CW)) u_fifo (
    .clk(i_clk),
    .rst(i_rst_n),
    .push(push),
    .pop(i_letter_ready),
    .flush(flush),
    .din(cur_q[0]),
    .head(o_letter),
    .full(full),
    .empty(empty)
  );
  assign o_letter_valid = ~empty;
  assign o_dd_next = dd_next_q;
  assign o_timeout = timeout_q;
  assign o_dd_tops = cur_q;
  assign o_dd_prev_tops = prev_q;
  assign o_accept_cnt = acc_q;
  assign o_drop_cnt = drop_q;
endmodule

// File: tb/tb_dedup_sequencer.sv
// tb_dedup_sequencer: directed scoreboard bench for dedup_sequencer
module tb_dedup_sequencer;
  logic clk = 0, rst = 1, i_valid = 0, i_clear = 0, i_dd_finished = 0, i_dd_next = 0, i_letter_ready = 1;
  logic [4:0] i_tops [3] = '{default: '0};
  logic o_ready, o_dd_next, o_letter_valid, o_timeout;
  logic [4:0] o_dd_tops [3], o_dd_prev_tops [3], o_letter;
  logic [15:0] o_accept_cnt, o_drop_cnt;
  int cyc = 0, n_chk = 0, n_fail = 0, dd_pulses = 0, to_pulses = 0, dd_mode = 0;
  logic prev_dd = 0;
  int exp_q [$];

  dedup_sequencer dut (
    .i_clk(clk), .i_rst_n(rst), .i_valid(i_valid), .i_tops(i_tops), .o_ready(o_ready),
    .i_clear(i_clear), .o_dd_next(o_dd_next), .o_dd_tops(o_dd_tops), .o_dd_prev_tops(o_dd_prev_tops),
    .i_dd_finished(i_dd_finished), .i_dd_next(i_dd_next), .o_letter(o_letter),
    .o_letter_valid(o_letter_valid), .i_letter_ready(i_letter_ready), .o_timeout(o_timeout),
    .o_accept_cnt(o_accept_cnt), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [14:0] pk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {a, b, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int c, output int t);
    int k;
    @(negedge clk);
    i_valid = 1;
    i_tops[0] = 5'(a);
    i_tops[1] = 5'(b);
    i_tops[2] = 5'(c);
    #1;
    k = 0;
    while (!o_ready && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!o_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_wait: got o_ready 0 expected 1 for frame %0d", a);
    end
    t = cyc;
    @(negedge clk);
    i_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    i_valid = 0;
    i_clear = 0;
    i_letter_ready = 1;
    dd_mode = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    dd_pulses = 0;
    to_pulses = 0;
    exp_q.delete();
  endtask

  task automatic drain();
    i_letter_ready = 1;
    repeat (12) @(negedge clk);
    #1;
    check("sb_empty", exp_q.size(), 0);
    check("drain_lv", o_letter_valid, 0);
  endtask

  // Dedup model: finish three cycles after the start pulse
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst && o_dd_next && dd_mode != 2) begin
      repeat (3) @(negedge clk);
      i_dd_finished = 1;
      i_dd_next = (dd_mode == 1);
      @(negedge clk);
      i_dd_finished = 0;
      i_dd_next = 0;
    end
  end

  // Monitor: letter scoreboard plus pulse bookkeeping
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) prev_dd = 0;
    else begin
      if (o_dd_next) begin
        dd_pulses++;
        check("dd_next_width", prev_dd, 0);
      end
      prev_dd = o_dd_next;
      if (o_timeout) to_pulses++;
      if (o_letter_valid && i_letter_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL letter_extra: got %0d expected none", o_letter);
        end else check("letter", o_letter, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t, t2;
    // 1: reset values and bypass
    do_reset();
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_lv", o_letter_valid, 0);
    check("rst_acc", o_accept_cnt, 0);
    check("rst_drop", o_drop_cnt, 0);
    check("rst_dd_next", o_dd_next, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_dd_tops", pk(o_dd_tops[0], o_dd_tops[1], o_dd_tops[2]), 0);
    exp_q.push_back(3);
    send(3, 7, 9, t);
    at(t + 1);
    check("byp_lv_t1", o_letter_valid, 0);
    at(t + 2);
    check("byp_lv_t2", o_letter_valid, 1);
    check("byp_letter", o_letter, 3);
    check("byp_acc", o_accept_cnt, 1);
    drain();
    check("byp_dd_pulses", dd_pulses, 0);
    // 2: duplicate dropped by Dedup
    do_reset();
    exp_q.push_back(3);
    send(3, 7, 9, t);
    send(3, 9, 1, t);
    at(t + 1);
    check("dup_dd_next", o_dd_next, 1);
    check("dup_dd_tops", pk(o_dd_tops[0], o_dd_tops[1], o_dd_tops[2]), pk(5'd3, 5'd9, 5'd1));
    check("dup_dd_prev", pk(o_dd_prev_tops[0], o_dd_prev_tops[1], o_dd_prev_tops[2]), pk(5'd3, 5'd7, 5'd9));
    at(t + 2);
    check("dup_dd_next_low", o_dd_next, 0);
    at(t + 4);
    check("dup_drop_t4", o_drop_cnt, 0);
    check("dup_ready_t4", o_ready, 0);
    at(t + 5);
    check("dup_drop_t5", o_drop_cnt, 1);
    check("dup_ready_t5", o_ready, 1);
    check("dup_acc", o_accept_cnt, 1);
    drain();
    check("dup_dd_pulses", dd_pulses, 1);
    // 3: blank separator lets a repeat through
    do_reset();
    i_letter_ready = 0;
    exp_q.push_back(3);
    send(3, 7, 9, t);
    send(26, 0, 1, t);
    at(t + 1);
    check("blank_acc", o_accept_cnt, 1);
    check("blank_drop", o_drop_cnt, 0);
    exp_q.push_back(3);
    send(3, 7, 9, t);
    at(t + 2);
    check("blank_lv", o_letter_valid, 1);
    check("blank_acc2", o_accept_cnt, 2);
    check("blank_dd_pulses", dd_pulses, 0);
    drain();
    // 4: new symbol through Dedup
    do_reset();
    exp_q.push_back(3);
    send(3, 7, 9, t);
    dd_mode = 1;
    exp_q.push_back(5);
    send(5, 12, 20, t);
    at(t + 1);
    check("new_dd_next", o_dd_next, 1);
    for (int k = 1; k <= 4; k++) begin
      at(t + k);
      check("new_prev_hold", pk(o_dd_prev_tops[0], o_dd_prev_tops[1], o_dd_prev_tops[2]), pk(5'd3, 5'd7, 5'd9));
      if (k == 2) check("new_dd_next_low", o_dd_next, 0);
    end
    at(t + 5);
    check("new_lv_t5", o_letter_valid, 0);
    at(t + 6);
    check("new_lv_t6", o_letter_valid, 1);
    check("new_letter", o_letter, 5);
    check("new_acc", o_accept_cnt, 2);
    drain();
    check("new_dd_pulses", dd_pulses, 1);
    // 5: watchdog
    do_reset();
    exp_q.push_back(3);
    send(3, 7, 9, t);
    dd_mode = 2;
    send(4, 1, 2, t);
    at(t + 16);
    check("wd_to_t16", o_timeout, 0);
    check("wd_ready_t16", o_ready, 0);
    at(t + 17);
    check("wd_to_t17", o_timeout, 1);
    check("wd_ready_t17", o_ready, 1);
    check("wd_drop", o_drop_cnt, 1);
    at(t + 18);
    check("wd_to_t18", o_timeout, 0);
    check("wd_pulses", to_pulses, 1);
    drain();
    // clear in idle flushes FIFO and forgets previous frame
    do_reset();
    i_letter_ready = 0;
    exp_q.push_back(3);
    send(3, 7, 9, t);
    at(t + 2);
    check("clr_lv_before", o_letter_valid, 1);
    @(negedge clk);
    i_clear = 1;
    #1;
    check("clr_ready", o_ready, 0);
    @(negedge clk);
    i_clear = 0;
    exp_q.delete();
    #1;
    check("clr_lv_after", o_letter_valid, 0);
    check("clr_acc_kept", o_accept_cnt, 1);
    exp_q.push_back(3);
    send(3, 7, 9, t);
    at(t + 2);
    check("clr_rebypass_lv", o_letter_valid, 1);
    check("clr_dd_pulses", dd_pulses, 0);
    drain();
    // 6: back-pressure with full FIFO
    do_reset();
    i_letter_ready = 0;
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(i);
      send(i, i + 1, i + 2, t);
      if (i < 8) send(26, 0, 0, t2);
    end
    at(t + 2);
    check("full_ready", o_ready, 0);
    check("full_lv", o_letter_valid, 1);
    check("full_acc", o_accept_cnt, 8);
    @(negedge clk);
    i_valid = 1;
    i_tops[0] = 5'd26;
    i_tops[1] = 5'd0;
    i_tops[2] = 5'd0;
    repeat (3) @(negedge clk);
    #1;
    check("full_stall", o_ready, 0);
    @(negedge clk);
    i_letter_ready = 1;
    #1;
    check("full_pop_cycle", o_ready, 0);
    @(negedge clk);
    i_letter_ready = 0;
    #1;
    check("full_ready_back", o_ready, 1);
    @(negedge clk);
    i_valid = 0;
    exp_q.push_back(9);
    send(9, 10, 11, t);
    at(t + 2);
    check("full_acc9", o_accept_cnt, 9);
    check("full_dd_pulses", dd_pulses, 0);
    drain();
    // reset in the middle of a Dedup wait
    dd_mode = 1;
    send(4, 1, 2, t);
    at(t + 2);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    check("mrst_ready", o_ready, 1);
    check("mrst_dd_next", o_dd_next, 0);
    check("mrst_timeout", o_timeout, 0);
    check("mrst_acc", o_accept_cnt, 0);
    check("mrst_drop", o_drop_cnt, 0);
    check("mrst_lv", o_letter_valid, 0);
    check("mrst_tops", pk(o_dd_tops[0], o_dd_tops[1], o_dd_tops[2]), 0);
    check("mrst_prev", pk(o_dd_prev_tops[0], o_dd_prev_tops[1], o_dd_prev_tops[2]), 0);
    at(t + 10);
    check("mrst_acc_late", o_accept_cnt, 0);
    check("mrst_lv_late", o_letter_valid, 0);
    check("mrst_sb", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
